// File: rtl/banked_frame_buffer.sv
// banked_frame_buffer: NO_BANKS frame stores handed from one writer to one reader
// through an age-ordered queue of published (READY) banks.
module banked_frame_buffer #(
    parameter  int NO_BANKS   = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int DEPTH      = 1024,
    parameter  int OVERWRITE  = 0,
    localparam int ADDR_WIDTH = $clog2(DEPTH),
    localparam int BANK_W     = $clog2(NO_BANKS),
    localparam int CNT_W      = $clog2(NO_BANKS + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] addr_wr,
    input  logic [DATA_WIDTH-1:0] data_wr,
    input  logic                  wr_commit,
    output logic                  wr_ready,
    output logic [BANK_W-1:0]     wr_bank,
    input  logic                  rd_acquire,
    input  logic                  rd_release,
    output logic                  rd_valid,
    output logic [BANK_W-1:0]     rd_bank,
    input  logic                  rd_en,
    input  logic [ADDR_WIDTH-1:0] addr_rd,
    output logic [DATA_WIDTH-1:0] data_rd,
    output logic                  data_rd_valid,
    output logic [CNT_W-1:0]      ready_count,
    output logic [15:0]           drop_count
);
    logic [DATA_WIDTH-1:0] mem [NO_BANKS][DEPTH];
    logic [BANK_W-1:0]     q_q [NO_BANKS];
    logic [BANK_W-1:0]     q_d [NO_BANKS];
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [BANK_W-1:0]     wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, free_idx;
    logic                  wr_ready_q, wr_ready_d, rd_valid_q, rd_valid_d;
    logic [15:0]           drop_q, drop_d;
    logic [DATA_WIDTH-1:0] data_rd_q;
    logic                  data_rd_valid_q;
    logic                  rel, acq, commit, free_ok, in_q;

    always_comb begin
        rel        = rd_release && rd_valid_q;
        acq        = rd_acquire && (!rd_valid_q || rel) && (cnt_q != '0);
        commit     = wr_commit && wr_ready_q;
        free_ok    = 1'b0;
        free_idx   = '0;
        in_q       = 1'b0;
        q_d        = q_q;
        cnt_d      = cnt_q;
        wr_bank_d  = wr_bank_q;
        wr_ready_d = wr_ready_q;
        rd_bank_d  = rd_bank_q;
        rd_valid_d = rd_valid_q;
        drop_d     = drop_q;
        // A bank being released this cycle already counts as free for the refill choice
        for (int b = NO_BANKS - 1; b >= 0; b--) begin
            in_q = 1'b0;
            for (int i = 0; i < NO_BANKS; i++)
                if (CNT_W'(i) < cnt_q && q_q[i] == BANK_W'(b)) in_q = 1'b1;
            if (!in_q && !(wr_ready_q && wr_bank_q == BANK_W'(b))
                      && !(rd_valid_q && !rel && rd_bank_q == BANK_W'(b))) begin
                free_ok  = 1'b1;
                free_idx = BANK_W'(b);
            end
        end
        if (rel) rd_valid_d = 1'b0;
        if (acq) begin
            rd_bank_d  = q_d[0];
            rd_valid_d = 1'b1;
            for (int i = 0; i < NO_BANKS - 1; i++) q_d[i] = q_d[i + 1];
            cnt_d = cnt_d - CNT_W'(1);
        end
        if (commit) begin
            if (free_ok) begin
                q_d[cnt_d[BANK_W-1:0]] = wr_bank_q;
                cnt_d     = cnt_d + CNT_W'(1);
                wr_bank_d = free_idx;
            end else if (OVERWRITE == 0) begin
                q_d[cnt_d[BANK_W-1:0]] = wr_bank_q;
                cnt_d      = cnt_d + CNT_W'(1);
                wr_ready_d = 1'b0;
            end else begin
                drop_d = (drop_q == 16'hFFFF) ? drop_q : drop_q + 16'd1;
                // With nothing left to recycle the committing frame itself is dropped
                if (cnt_d != '0) begin
                    wr_bank_d = q_d[0];
                    for (int i = 0; i < NO_BANKS - 1; i++) q_d[i] = q_d[i + 1];
                    q_d[cnt_d[BANK_W-1:0] - BANK_W'(1)] = wr_bank_q;
                end
            end
        end else if (!wr_ready_q && rel) begin
            wr_ready_d = 1'b1;
            wr_bank_d  = rd_bank_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NO_BANKS; i++) q_q[i] <= '0;
            cnt_q           <= '0;
            wr_bank_q       <= '0;
            wr_ready_q      <= 1'b1;
            rd_bank_q       <= '0;
            rd_valid_q      <= 1'b0;
            drop_q          <= '0;
            data_rd_q       <= '0;
            data_rd_valid_q <= 1'b0;
        end else begin
            q_q             <= q_d;
            cnt_q           <= cnt_d;
            wr_bank_q       <= wr_bank_d;
            wr_ready_q      <= wr_ready_d;
            rd_bank_q       <= rd_bank_d;
            rd_valid_q      <= rd_valid_d;
            drop_q          <= drop_d;
            data_rd_valid_q <= rd_en && rd_valid_q;
            if (rd_en && rd_valid_q) data_rd_q <= mem[rd_bank_q][addr_rd];
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_ready_q) mem[wr_bank_q][addr_wr] <= data_wr;
    end

    assign wr_ready      = wr_ready_q;
    assign wr_bank       = wr_bank_q;
    assign rd_valid      = rd_valid_q;
    assign rd_bank       = rd_bank_q;
    assign data_rd       = data_rd_q;
    assign data_rd_valid = data_rd_valid_q;
    assign ready_count   = cnt_q;
    assign drop_count    = drop_q;
endmodule

// File: tb/tb_banked_frame_buffer.sv
// tb_banked_frame_buffer: drives an OVERWRITE=0 and an OVERWRITE=1 instance with
// identical stimulus and checks both against a bank-state/queue reference model.
module tb_banked_frame_buffer;
    localparam int FREE = 0, FILL = 1, RDY = 2, RD = 3;

    logic        clk = 1'b0, rst_n = 1'b1;
    logic        wr_en = 0, wr_commit = 0, rd_acquire = 0, rd_release = 0, rd_en = 0;
    logic [3:0]  addr_wr = 0, addr_rd = 0;
    logic [15:0] data_wr = 0;
    logic        wr_ready [2];
    logic [1:0]  wr_bank [2];
    logic        rd_valid [2];
    logic [1:0]  rd_bank [2];
    logic [15:0] data_rd [2];
    logic        data_rd_valid [2];
    logic [2:0]  ready_count [2];
    logic [15:0] drop_count [2];

    int          ncmp = 0, nerr = 0;
    int          st [2][4];
    int          qa [2][4];
    int          qn [2];
    int          drop [2];
    logic [15:0] mm [2][4][16];
    bit          mk [2][4][16];
    logic [15:0] md [2];
    bit          mdk [2], mdv [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        banked_frame_buffer #(.NO_BANKS(4), .DATA_WIDTH(16), .DEPTH(16), .OVERWRITE(g)) u_dut (
            .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .addr_wr(addr_wr), .data_wr(data_wr),
            .wr_commit(wr_commit), .wr_ready(wr_ready[g]), .wr_bank(wr_bank[g]),
            .rd_acquire(rd_acquire), .rd_release(rd_release), .rd_valid(rd_valid[g]),
            .rd_bank(rd_bank[g]), .rd_en(rd_en), .addr_rd(addr_rd), .data_rd(data_rd[g]),
            .data_rd_valid(data_rd_valid[g]), .ready_count(ready_count[g]),
            .drop_count(drop_count[g])
        );
    end

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int find(int k, int s);
        for (int b = 0; b < 4; b++) if (st[k][b] == s) return b;
        return -1;
    endfunction

    task automatic qpop(input int k, output int h);
        h = qa[k][0];
        for (int i = 0; i < 3; i++) qa[k][i] = qa[k][i + 1];
        qn[k]--;
    endtask

    task automatic qpush(input int k, input int b);
        qa[k][qn[k]] = b;
        qn[k]++;
        st[k][b] = RDY;
    endtask

    task automatic model_reset(int k);
        for (int b = 0; b < 4; b++) st[k][b] = FREE;
        st[k][0] = FILL;
        qn[k] = 0; drop[k] = 0; md[k] = 0; mdk[k] = 1; mdv[k] = 0;
    endtask

    task automatic model_step(int k);
        int fb, rb, f, h;
        bit rel, acq, com;
        fb  = find(k, FILL);
        rb  = find(k, RD);
        rel = rd_release && rb >= 0;
        acq = rd_acquire && (rb < 0 || rel) && qn[k] > 0;
        com = wr_commit && fb >= 0;
        if (rd_en && rb >= 0) begin
            md[k] = mm[k][rb][addr_rd]; mdk[k] = mk[k][rb][addr_rd]; mdv[k] = 1;
        end else mdv[k] = 0;
        if (wr_en && fb >= 0) begin
            mm[k][fb][addr_wr] = data_wr; mk[k][fb][addr_wr] = 1;
        end
        if (rel) st[k][rb] = FREE;
        if (acq) begin qpop(k, h); st[k][h] = RD; end
        if (com) begin
            f = find(k, FREE);
            if (f >= 0) begin qpush(k, fb); st[k][f] = FILL; end
            else if (k == 0) qpush(k, fb);
            else begin
                if (drop[k] < 16'hFFFF) drop[k]++;
                if (qn[k] > 0) begin qpop(k, h); st[k][h] = FILL; qpush(k, fb); end
            end
        end else if (fb < 0 && rel) st[k][rb] = FILL;
    endtask

    task automatic check_all(int k);
        int fb, rb;
        fb = find(k, FILL);
        rb = find(k, RD);
        chk($sformatf("wr_ready[%0d]", k), wr_ready[k], fb >= 0);
        if (fb >= 0) chk($sformatf("wr_bank[%0d]", k), wr_bank[k], fb);
        chk($sformatf("rd_valid[%0d]", k), rd_valid[k], rb >= 0);
        if (rb >= 0) chk($sformatf("rd_bank[%0d]", k), rd_bank[k], rb);
        chk($sformatf("ready_count[%0d]", k), ready_count[k], qn[k]);
        chk($sformatf("drop_count[%0d]", k), drop_count[k], drop[k]);
        chk($sformatf("data_rd_valid[%0d]", k), data_rd_valid[k], mdv[k]);
        if (mdk[k]) chk($sformatf("data_rd[%0d]", k), data_rd[k], md[k]);
    endtask

    task automatic step(bit we, logic [3:0] wa, logic [15:0] wd, bit wc, bit ra, bit rr,
                        bit re, logic [3:0] ra_addr);
        @(negedge clk);
        wr_en = we; addr_wr = wa; data_wr = wd; wr_commit = wc;
        rd_acquire = ra; rd_release = rr; rd_en = re; addr_rd = ra_addr;
        @(posedge clk);
        model_step(0);
        model_step(1);
        #1;
        check_all(0);
        check_all(1);
    endtask

    task automatic do_reset();
        @(negedge clk);
        wr_en = 0; wr_commit = 0; rd_acquire = 0; rd_release = 0; rd_en = 0;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            model_reset(k);
            check_all(k);
            chk($sformatf("rst_wr_bank[%0d]", k), wr_bank[k], 0);
            chk($sformatf("rst_rd_bank[%0d]", k), rd_bank[k], 0);
            chk($sformatf("rst_data_rd[%0d]", k), data_rd[k], 0);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();
        // Single frame round trip
        step(1, 3, 16'h00A5, 0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("rt_wr_bank", wr_bank[0], 1);
        chk("rt_ready_after_commit", ready_count[0], 1);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        chk("rt_ready_after_acquire", ready_count[0], 0);
        chk("rt_rd_bank", rd_bank[0], 0);
        step(0, 0, 0, 0, 0, 0, 1, 3);
        chk("rt_data_rd", data_rd[0], 16'h00A5);
        chk("rt_data_rd_valid", data_rd_valid[0], 1);
        // Writer stalls when every bank is taken, then refills from the released bank
        for (int i = 0; i < 3; i++) step(1, 4'(i), 16'(16'h100 + i), 1, 0, 0, 0, 0);
        chk("stall_wr_ready", wr_ready[0], 0);
        step(1, 7, 16'hDEAD, 1, 0, 0, 0, 0);
        chk("stall_ready_count", ready_count[0], 3);
        step(0, 0, 0, 0, 1, 1, 0, 0);
        chk("resume_wr_ready", wr_ready[0], 1);
        chk("resume_wr_bank", wr_bank[0], 0);
        // Overwrite drops the oldest frames
        do_reset();
        for (int i = 0; i < 5; i++) step(1, 0, 16'(16'h200 + i), 1, 0, 0, 0, 0);
        chk("ovw_drop_count", drop_count[1], 2);
        chk("ovw_ready_count", ready_count[1], 3);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        chk("ovw_head", rd_bank[1], 2);
        step(0, 0, 0, 0, 0, 0, 1, 0);
        chk("ovw_frame3_data", data_rd[1], 16'h202);
        // Release and acquire together swap to the next oldest frame
        step(0, 0, 0, 0, 1, 1, 0, 0);
        chk("swap_rd_valid", rd_valid[1], 1);
        chk("swap_rd_bank", rd_bank[1], 3);
        chk("swap_ready_count", ready_count[1], 1);
        step(0, 0, 0, 0, 1, 1, 1, 0);
        chk("swap_last_bank", rd_bank[1], 0);
        for (int n = 0; n < 1500; n++) begin
            if ($urandom_range(299) == 0) do_reset();
            step($urandom_range(1), 4'($urandom_range(15)), 16'($urandom), $urandom_range(5) == 0,
                 $urandom_range(3) == 0, $urandom_range(4) == 0, $urandom_range(1),
                 4'($urandom_range(15)));
        end
        // Reset while a frame is held and a read is in flight
        do_reset();
        step(1, 1, 16'h0BEE, 1, 0, 0, 0, 0);
        step(0, 0, 0, 0, 1, 0, 0, 0);
        step(1, 2, 16'h0CAB, 0, 0, 0, 1, 1);
        chk("mid_rd_valid_before", rd_valid[0], 1);
        chk("mid_data_valid_before", data_rd_valid[0], 1);
        do_reset();
        chk("mid_data_valid_after", data_rd_valid[0], 0);
        chk("mid_rd_valid_after", rd_valid[0], 0);
        step(0, 0, 0, 1, 0, 0, 0, 0);
        chk("post_rst_ready_count", ready_count[0], 1);
        chk("post_rst_wr_bank", wr_bank[0], 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end
endmodule

// File: doc/banked_frame_buffer.md
BANKED_FRAME_BUFFER -- requirements
Module: banked_frame_buffer

Interface
REQ-001 Parameters SHALL be:
- NO_BANKS, 4, bank count (>=2).
- DATA_WIDTH, 16, word width.
- DEPTH, 1024, words per bank.
- OVERWRITE, 0, 1 = drop oldest ready frame when no bank is free.
REQ-002 Localparams SHALL be ADDR_WIDTH = $clog2(DEPTH) and BANK_W = $clog2(NO_BANKS).
REQ-003 Ports SHALL be (name, direction, width, meaning):
- clk, in, 1, single clock for all logic and memory.
- rst_n, in, 1, asynchronous active-low reset.
- wr_en, in, 1, write strobe.
- addr_wr, in, ADDR_WIDTH, write address.
- data_wr, in, DATA_WIDTH, write data.
- wr_commit, in, 1, publish the current fill bank as a frame.
- wr_ready, out, 1, a fill bank is held.
- wr_bank, out, BANK_W, index of the fill bank.
- rd_acquire, in, 1, claim the oldest ready frame.
- rd_release, in, 1, return the held bank.
- rd_valid, out, 1, reader holds a bank.
- rd_bank, out, BANK_W, index of the held bank.
- rd_en, in, 1, read strobe.
- addr_rd, in, ADDR_WIDTH, read address.
- data_rd, out, DATA_WIDTH, registered read data.
- data_rd_valid, out, 1, data_rd qualifier.
- ready_count, out, $clog2(NO_BANKS+1), number of READY banks.
- drop_count, out, 16, saturating count of dropped frames.

Function
REQ-004 Each bank SHALL be in exactly one state: FREE, FILL, READY or READ; at most one bank SHALL be in FILL and at most one in READ.
REQ-005 READY banks SHALL be tracked in an age-ordered queue of depth NO_BANKS; "oldest" means the queue head.
REQ-006 wr_en with wr_ready=1 SHALL write data_wr to bank wr_bank at addr_wr on that edge; wr_en with wr_ready=0 SHALL be ignored.
REQ-007 wr_commit with wr_ready=1 SHALL move the FILL bank to READY (queue tail) and, on the same edge, move the lowest-index FREE bank to FILL.
REQ-008 wr_en and wr_commit in the same cycle SHALL write to the committing bank before it is published.
REQ-009 On commit with no FREE bank and OVERWRITE=0, wr_ready SHALL be 0 from the next cycle; wr_commit and wr_en SHALL be ignored while wr_ready=0.
REQ-010 On commit with no FREE bank and OVERWRITE=1, the oldest READY bank SHALL be removed from the queue and become FILL, drop_count SHALL increment, and wr_ready SHALL stay 1.
REQ-011 rd_acquire with rd_valid=0 and ready_count>0 SHALL move the queue head to READ, load rd_bank, and set rd_valid=1 the next cycle; otherwise rd_acquire SHALL be ignored.
REQ-012 rd_en with rd_valid=1 SHALL present mem[rd_bank][addr_rd] on data_rd one cycle later with data_rd_valid=1 for one cycle; data_rd SHALL hold its value otherwise.
REQ-013 rd_release with rd_valid=1 SHALL move the READ bank to FREE and set rd_valid=0 the next cycle.
REQ-014 If wr_ready=0 when a bank is released, the released bank SHALL go directly to FILL and wr_ready SHALL be 1 the next cycle.
REQ-015 rd_release with rd_acquire in the same cycle SHALL release the held bank and acquire the next oldest READY bank on the same edge; rd_valid SHALL stay 1 if one exists.
REQ-016 rd_acquire in the same cycle as commit evaluation SHALL take priority for the queue head.
REQ-017 If REQ-016 leaves no READY bank to recycle under OVERWRITE=1, the committing bank SHALL remain FILL unpublished and drop_count SHALL increment.
REQ-018 Memory writes, state changes and count updates SHALL all occur on the same clk edge; ready_count SHALL equal the queue occupancy.
REQ-019 drop_count SHALL saturate at 16'hFFFF.

Reset
REQ-020 rst_n=0 SHALL asynchronously set bank 0 to FILL and all other banks to FREE.
REQ-021 rst_n=0 SHALL asynchronously set wr_bank=0, wr_ready=1, rd_valid=0, rd_bank=0, data_rd=0, data_rd_valid=0, ready_count=0, drop_count=0, and empty the queue.
REQ-022 Memory contents SHALL NOT be cleared by reset.
REQ-023 Reset asserted mid-frame SHALL discard all frame ownership; in-flight read data SHALL NOT be flagged valid after reset.

Verification
REQ-024 NO_BANKS=4: write 0xA5 at addr 3 to bank 0, commit, acquire, rd_en at addr 3 -> wr_bank=1, ready_count 1->0, rd_bank=0, data_rd=0xA5 one cycle after rd_en.
REQ-025 OVERWRITE=0: commit 3 frames with no acquire -> after the 3rd commit wr_ready=0 and writes are ignored; acquire then release -> wr_ready=1 next cycle with wr_bank=0.
REQ-026 OVERWRITE=1: commit 5 frames with no acquire -> drop_count=2, ready_count=3, queue holds frames 3,4,5 in order.
REQ-027 Assert rd_release and rd_acquire together with ready_count=2 -> rd_valid stays 1, rd_bank = next oldest, ready_count=1.
REQ-028 Pulse rst_n low mid-frame while rd_valid=1 -> all outputs at reset values immediately; first post-reset commit yields ready_count=1 with wr_bank=1.
